// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access unit with lane extract, sign extend and sub-word read-modify-write
module mem_access_unit #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        RMW_WR,
        WR,
        RESP,
        ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        misaligned;
    logic [4:0]  lane_shift;
    logic [15:0] lane;
    logic [31:0] lane_mask;
    logic [31:0] load_value;
    logic [31:0] merged;

    // req_ready is a flop so it stays low on the reset edge and rises one edge later.
    assign accept = (state == IDLE) && req_ready && req_valid;

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == SIZE_HALF) & req_addr[0])
                      | ((req_size == SIZE_WORD) & (|req_addr[1:0]));

    // Bit position of the addressed lane inside the memory word.
    always_comb begin
        lane_shift = 5'd0;
        if (size_q == SIZE_BYTE) begin
            lane_shift = (BIG_ENDIAN != 0) ? {~off_q, 3'b000} : {off_q, 3'b000};
        end else if (size_q == SIZE_HALF) begin
            lane_shift = (BIG_ENDIAN != 0) ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
        end
    end

    assign lane = 16'(mem_data >> lane_shift);

    always_comb begin
        load_value = mem_data;
        case (size_q)
            SIZE_BYTE: load_value = {{24{signed_q & lane[7]}}, lane[7:0]};
            SIZE_HALF: load_value = {{16{signed_q & lane[15]}}, lane[15:0]};
            default:   load_value = mem_data;
        endcase
    end

    assign lane_mask = ((size_q == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
    assign merged    = (mem_data & ~lane_mask) | (({16'h0000, wdata_q} << lane_shift) & lane_mask);

    assign resp_valid = (state == RESP) || (state == ERR);
    assign resp_err   = (state == ERR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        next_state = ERR;
                    end else if (!req_write) begin
                        next_state = RD;
                    end else if (req_size == SIZE_WORD) begin
                        next_state = WR;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD:     if (mem_ack) next_state = RESP;
            RMW_RD: if (mem_ack) next_state = RMW_WR;
            // First RMW_WR cycle has mem_req low (the mandatory gap); ack only counts once it is raised.
            RMW_WR: if (mem_req && mem_ack) next_state = RESP;
            WR:     if (mem_ack) next_state = RESP;
            RESP:   next_state = IDLE;
            ERR:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready      <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_req        <= 1'b0;
            mem_addr       <= 32'h0;
            mem_write_en   <= 1'b0;
            mem_write_data <= 32'h0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            off_q          <= 2'b00;
            wdata_q        <= 16'h0;
        end else begin
            req_ready <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q         <= req_size;
                        signed_q       <= req_signed;
                        off_q          <= req_addr[1:0];
                        wdata_q        <= req_wdata[15:0];
                        mem_addr       <= {req_addr[31:2], 2'b00};
                        mem_req        <= (next_state != ERR);
                        mem_write_en   <= (next_state == WR);
                        mem_write_data <= req_wdata;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_rdata <= load_value;
                    end
                end
                RMW_RD: begin
                    if (mem_ack) begin
                        mem_req        <= 1'b0;
                        mem_write_data <= merged;
                    end
                end
                RMW_WR: begin
                    if (!mem_req) begin
                        mem_req      <= 1'b1;
                        mem_write_en <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req      <= 1'b0;
                        mem_write_en <= 1'b0;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        mem_write_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
